// File: rtl/freq_meter_if.sv
// Host-side bundle for the frequency meter: measurement request controls
// going in, window status and the latched result coming back.
interface freq_meter_if #(
  parameter int CNT_W = 32
) ();
  logic             start;
  logic             continuous;
  logic             busy;
  logic [CNT_W-1:0] freq;
  logic             overflow;
  logic             valid;

  modport master (
    output start,
    output continuous,
    input  busy,
    input  freq,
    input  overflow,
    input  valid
  );

  modport slave (
    input  start,
    input  continuous,
    output busy,
    output freq,
    output overflow,
    output valid
  );
endinterface

// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of an asynchronous
// pin over a fixed window of GATE_CYCLES clocks and latches the count.
// With the default 1 s gate at 25 MHz, the result reads directly in Hz.
module freq_meter #(
  parameter int GATE_CYCLES = 25000000,
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  freq_meter_if.slave  bus
);

  typedef enum logic {IDLE, GATE} state_t;

  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic              sync1_q, sync2_q, sync3_q;
  logic              rise;

  state_t            state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  freq_q, freq_d;
  logic              overflow_q, overflow_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [CNT_W-1:0]  edge_inc;
  logic              ovf_inc;

  // Two-flop synchronizer on the pin plus a delay flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;

  // Control and result registers; everything visible outside is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gate_q     <= '0;
      edge_q     <= '0;
      ovf_q      <= 1'b0;
      freq_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      edge_q     <= edge_d;
      ovf_q      <= ovf_d;
      freq_q     <= freq_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: open a window, count edges with saturation, and at the
  // last gate cycle publish the count (including that cycle's edge) and
  // either reload seamlessly or fall back to idle.
  always_comb begin
    edge_inc = edge_q;
    ovf_inc  = ovf_q;
    if (rise) begin
      if (edge_q == CNT_MAX) begin
        ovf_inc = 1'b1;
      end else begin
        edge_inc = edge_q + CNT_W'(1);
      end
    end

    state_d    = state_q;
    gate_d     = gate_q;
    edge_d     = edge_q;
    ovf_d      = ovf_q;
    freq_d     = freq_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start || bus.continuous) begin
          state_d = GATE;
          gate_d  = GATE_LOAD;
          edge_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      GATE: begin
        if (gate_q == '0) begin
          freq_d     = edge_inc;
          overflow_d = ovf_inc;
          valid_d    = 1'b1;
          if (bus.continuous) begin
            gate_d = GATE_LOAD;
            edge_d = '0;
            ovf_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gate_d = gate_q - GATE_W'(1);
          edge_d = edge_inc;
          ovf_d  = ovf_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == GATE);
  end

  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.freq     = freq_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: two instances (8-bit and 4-bit edge
// counters, 100-cycle gate) share all stimulus. A transaction-level model
// tracks gate windows from the requests driven and counts expected edges
// from the recorded pin history.
module tb_freq_meter;

  localparam int G    = 100;
  localparam int MAXC = 8000;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic sigIn = 1'b0;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  bit sigHist [MAXC];

  int winA    = -1;
  int winB    = -2;
  int validAt = -1;
  int doneA   = 0;
  int doneB   = -1;

  logic [31:0] expFreqA = '0;
  logic [31:0] expFreqB = '0;
  logic        expOvfA  = 1'b0;
  logic        expOvfB  = 1'b0;

  int   halfPer  = 0;
  int   phase    = 0;
  logic sigState = 1'b0;

  freq_meter_if #(.CNT_W(8)) busA ();
  freq_meter_if #(.CNT_W(4)) busB ();

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8), .GATE_W(7)) dutA (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sigIn),
    .bus    (busA)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .GATE_W(7)) dutB (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sigIn),
    .bus    (busB)
  );

  // 100 MHz-equivalent simulation clock; only relative timing matters.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d",
               tag, cyc, observed, expected);
    end
  endtask

  // A pin rising edge becomes visible to the counter two cycles after it is
  // driven; count those that fall inside the window cycles a..b.
  function automatic int riseCount(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) begin
      if (c >= 3 && sigHist[c-2] && !sigHist[c-3]) n++;
    end
    return n;
  endfunction

  task automatic checkCycle();
    logic expBusy;
    logic expValid;
    int   n;
    expBusy  = rst && (cyc >= winA) && (cyc <= winB);
    expValid = 1'b0;
    if (rst && cyc == validAt) begin
      n        = riseCount(doneA, doneB);
      expFreqA = (n > 255) ? 32'd255 : 32'(n);
      expOvfA  = (n > 255);
      expFreqB = (n > 15) ? 32'd15 : 32'(n);
      expOvfB  = (n > 15);
      expValid = 1'b1;
    end
    checkOutput("busyA",  32'(busA.busy),     32'(expBusy));
    checkOutput("validA", 32'(busA.valid),    32'(expValid));
    checkOutput("freqA",  32'(busA.freq),     expFreqA);
    checkOutput("ovfA",   32'(busA.overflow), 32'(expOvfA));
    checkOutput("busyB",  32'(busB.busy),     32'(expBusy));
    checkOutput("validB", 32'(busB.valid),    32'(expValid));
    checkOutput("freqB",  32'(busB.freq),     expFreqB);
    checkOutput("ovfB",   32'(busB.overflow), 32'(expOvfB));
  endtask

  task automatic applyStimulus(input logic st, input logic co);
    @(posedge clk);
    cyc++;
    #1;
    if (cyc >= MAXC) begin
      $display("[TB] FAIL cycleBudget: reached %0d cycles, limit %0d", cyc, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    checkCycle();
    if (halfPer > 0) begin
      phase++;
      if (phase >= halfPer) begin
        phase    = 0;
        sigState = ~sigState;
      end
    end else if (halfPer < 0) begin
      sigState = 1'($urandom_range(0, 1));
    end else begin
      sigState = 1'b0;
    end
    sigIn             = sigState;
    sigHist[cyc]      = sigState;
    busA.start        = st;
    busB.start        = st;
    busA.continuous   = co;
    busB.continuous   = co;
    if (rst) begin
      if (cyc == winB) begin
        doneA   = winA;
        doneB   = winB;
        validAt = cyc + 1;
        if (co) begin
          winA = cyc + 1;
          winB = cyc + G;
        end
      end else if (!(cyc >= winA && cyc <= winB) && (st || co)) begin
        winA = cyc + 1;
        winB = cyc + G;
      end
    end
  endtask

  task automatic runFor(input int n, input logic stFirst, input logic co);
    for (int i = 0; i < n; i++) applyStimulus((i == 0) ? stFirst : 1'b0, co);
  endtask

  task automatic doReset();
    #3;
    rst = 1'b0;
    #1;
    winA     = -1;
    winB     = -2;
    validAt  = -1;
    expFreqA = '0;
    expFreqB = '0;
    expOvfA  = 1'b0;
    expOvfB  = 1'b0;
    checkOutput("rstBusyA",  32'(busA.busy),     32'd0);
    checkOutput("rstValidA", 32'(busA.valid),    32'd0);
    checkOutput("rstFreqA",  32'(busA.freq),     32'd0);
    checkOutput("rstOvfA",   32'(busA.overflow), 32'd0);
    checkOutput("rstBusyB",  32'(busB.busy),     32'd0);
    checkOutput("rstFreqB",  32'(busB.freq),     32'd0);
  endtask

  initial begin
    busA.start      = 1'b0;
    busB.start      = 1'b0;
    busA.continuous = 1'b0;
    busB.continuous = 1'b0;
    #2;
    rst = 1'b0;

    // Reset state held for a few cycles, then release.
    runFor(4, 1'b0, 1'b0);
    rst = 1'b1;
    runFor(3, 1'b0, 1'b0);

    // Quiet pin: one full window reading zero.
    halfPer = 0;
    runFor(110, 1'b1, 1'b0);

    // Period-4 input: about 25 edges per window.
    halfPer = 2;
    phase   = 0;
    runFor(110, 1'b1, 1'b0);
    checkOutput("freqNear25", 32'(busA.freq >= 8'd24 && busA.freq <= 8'd26), 32'd1);

    // Period-2 input saturates the 4-bit counter; then a quiet window clears it.
    halfPer = 1;
    phase   = 0;
    runFor(110, 1'b1, 1'b0);
    checkOutput("satOvfB", 32'(busB.overflow), 32'd1);
    halfPer = 0;
    runFor(110, 1'b1, 1'b0);
    checkOutput("clearOvfB", 32'(busB.overflow), 32'd0);

    // Continuous back-to-back windows, dropped in the middle of window 3.
    halfPer = 5;
    phase   = 0;
    runFor(250, 1'b0, 1'b1);
    runFor(80, 1'b0, 1'b0);
    runFor(20, 1'b0, 1'b0);

    // Reset 50 cycles into a window, then a clean full window.
    halfPer = 0;
    runFor(5, 1'b0, 1'b0);
    runFor(50, 1'b1, 1'b0);
    doReset();
    runFor(3, 1'b0, 1'b0);
    rst = 1'b1;
    runFor(2, 1'b0, 1'b0);
    halfPer = 3;
    phase   = 0;
    runFor(110, 1'b1, 1'b0);

    // Start pulses during the window and on its last cycle are ignored.
    runFor(1, 1'b1, 1'b0);
    runFor(40, 1'b0, 1'b0);
    runFor(1, 1'b1, 1'b0);
    while (cyc + 1 < winB) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    runFor(20, 1'b0, 1'b0);

    // Random pin activity with random requests and continuous mode.
    halfPer = -1;
    for (int seg = 0; seg < 4; seg++) begin
      logic co;
      co = 1'($urandom_range(0, 1));
      for (int i = 0; i < 150; i++) begin
        applyStimulus(($urandom_range(0, 19) == 0), co);
      end
    end
    halfPer = 0;
    runFor(130, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
